// File: rtl/servo_pkg.sv
// Shared derivations, angle-to-duty mapping and FSM state type for the
// N-channel servo PWM generator.
package servo_pkg;

    typedef enum logic {
        IDLE,
        MAP
    } map_state_e;

    function automatic longint period_cycles(input longint clk_freq, input longint pwm_freq);
        return clk_freq / pwm_freq;
    endfunction

    function automatic longint dc_mid(input longint dc_min, input longint dc_max);
        return (dc_min + dc_max) / 2;
    endfunction

    function automatic longint clamp_angle(input longint a, input longint lo, input longint hi);
        if (a < lo) return lo;
        if (a > hi) return hi;
        return a;
    endfunction

    // 64-bit operands keep the product exact before the truncating divide.
    function automatic longint angle_to_dc(input longint a,
                                           input longint lo,
                                           input longint hi,
                                           input longint dc_min,
                                           input longint dc_max);
        return dc_min + ((clamp_angle(a, lo, hi) - lo) * (dc_max - dc_min)) / (hi - lo);
    endfunction

endpackage

// File: rtl/servo_slew_channel.sv
// One servo channel: target and slew-limited active duty, period-latched
// enable, registered PWM output and settled flag.
module servo_slew_channel
    import servo_pkg::*;
#(
    parameter int               CNT_W     = 32,
    parameter logic [CNT_W-1:0] DC_MID    = '0,
    parameter logic [CNT_W-1:0] SLEW_STEP = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [CNT_W-1:0] cnt_next_i,
    input  logic             wrap_i,
    input  logic             en_i,
    input  logic             wr_en_i,
    input  logic [CNT_W-1:0] wr_dc_i,
    output logic             pwm_o,
    output logic             settled_o
);

    logic [CNT_W-1:0] target_q, target_d;
    logic [CNT_W-1:0] active_q, active_d;
    logic             en_q, en_d;
    logic             pwm_q, pwm_d;
    logic             settled_q, settled_d;

    always_comb begin
        target_d = wr_en_i ? wr_dc_i : target_q;
        active_d = active_q;
        en_d     = en_q;
        // The slew step reads target_q, i.e. the value before a same-cycle write.
        if (wrap_i) begin
            en_d = en_i;
            if (SLEW_STEP == '0) begin
                active_d = target_q;
            end else if (target_q > active_q) begin
                active_d = ((target_q - active_q) > SLEW_STEP) ? active_q + SLEW_STEP : target_q;
            end else if (target_q < active_q) begin
                active_d = ((active_q - target_q) > SLEW_STEP) ? active_q - SLEW_STEP : target_q;
            end
        end
        pwm_d     = en_d && (cnt_next_i < active_d);
        settled_d = (active_d == target_d);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            target_q  <= DC_MID;
            active_q  <= DC_MID;
            en_q      <= 1'b0;
            pwm_q     <= 1'b0;
            settled_q <= 1'b1;
        end else begin
            target_q  <= target_d;
            active_q  <= active_d;
            en_q      <= en_d;
            pwm_q     <= pwm_d;
            settled_q <= settled_d;
        end
    end

    assign pwm_o     = pwm_q;
    assign settled_o = settled_q;

endmodule

// File: rtl/servo_pwm_multi.sv
// N-channel servo PWM generator: shared period counter, angle-to-duty mapping
// sequencer (one channel per cycle) and per-channel slew instances.
module servo_pwm_multi
    import servo_pkg::*;
#(
    parameter int NUM_CH    = 4,
    parameter int CLK_FREQ  = 25_000_000,
    parameter int PWM_FREQ  = 50,
    parameter int ANGLE_W   = 11,
    parameter int ANGLE_MIN = -270,
    parameter int ANGLE_MAX = 270,
    parameter int DC_MIN    = 25_000,
    parameter int DC_MAX    = 125_000,
    parameter int SLEW_STEP = 2_500,
    parameter int CNT_W     = 32
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_CH*ANGLE_W-1:0] angle_flat,
    input  logic                      angle_valid,
    output logic                      ready,
    input  logic [NUM_CH-1:0]         ch_enable,
    output logic [NUM_CH-1:0]         pwm_out,
    output logic                      period_start,
    output logic [NUM_CH-1:0]         settled
);

    localparam int PERIOD = int'(period_cycles(longint'(CLK_FREQ), longint'(PWM_FREQ)));
    localparam int DC_MID = int'(dc_mid(longint'(DC_MIN), longint'(DC_MAX)));
    localparam int IDX_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    generate
        if (DC_MAX >= PERIOD) begin : g_bad_dc_max
            $error("servo_pwm_multi: DC_MAX must be less than PERIOD");
        end
        if (NUM_CH < 1 || NUM_CH > 16) begin : g_bad_num_ch
            $error("servo_pwm_multi: NUM_CH must be in 1..16");
        end
    endgenerate

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             wrap;
    logic             period_start_q;

    assign wrap  = (cnt_q == CNT_W'(PERIOD - 1));
    assign cnt_d = wrap ? '0 : cnt_q + CNT_W'(1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q          <= '0;
            period_start_q <= 1'b0;
        end else begin
            cnt_q          <= cnt_d;
            period_start_q <= (cnt_d == '0);
        end
    end

    map_state_e                state_q, state_d;
    logic [IDX_W-1:0]          idx_q, idx_d;
    logic                      ready_q, ready_d;
    logic                      accept;
    logic                      map_wr;
    logic signed [ANGLE_W-1:0] angle_q [NUM_CH];
    logic signed [ANGLE_W-1:0] angle_d [NUM_CH];
    logic signed [ANGLE_W-1:0] cur_angle;
    logic [CNT_W-1:0]          map_dc;

    assign accept    = angle_valid && ready_q;
    assign cur_angle = angle_q[idx_q];
    assign map_dc    = CNT_W'(angle_to_dc(longint'(cur_angle), longint'(ANGLE_MIN),
                                          longint'(ANGLE_MAX), longint'(DC_MIN),
                                          longint'(DC_MAX)));

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        angle_d = angle_q;
        map_wr  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    for (int unsigned i = 0; i < NUM_CH; i++) begin
                        angle_d[i] = angle_flat[i*ANGLE_W +: ANGLE_W];
                    end
                    idx_d   = '0;
                    state_d = MAP;
                end
            end
            MAP: begin
                map_wr = 1'b1;
                if (idx_q == IDX_W'(NUM_CH - 1)) begin
                    idx_d   = '0;
                    state_d = IDLE;
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
        // Held low one cycle past the last write so ready spans NUM_CH+1 cycles.
        ready_d = (state_q == IDLE) && !accept;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            ready_q <= 1'b1;
            angle_q <= '{default: '0};
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            ready_q <= ready_d;
            angle_q <= angle_d;
        end
    end

    assign ready        = ready_q;
    assign period_start = period_start_q;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        servo_slew_channel #(
            .CNT_W    (CNT_W),
            .DC_MID   (CNT_W'(DC_MID)),
            .SLEW_STEP(CNT_W'(SLEW_STEP))
        ) u_ch (
            .clk       (clk),
            .rst       (rst),
            .cnt_next_i(cnt_d),
            .wrap_i    (wrap),
            .en_i      (ch_enable[g]),
            .wr_en_i   (map_wr && (idx_q == IDX_W'(g))),
            .wr_dc_i   (map_dc),
            .pwm_o     (pwm_out[g]),
            .settled_o (settled[g])
        );
    end

endmodule

// File: tb/tb_servo_pwm_multi.sv
// Bench for servo_pwm_multi: a jump instance (no slew) and a slew-limited
// instance share stimulus and are compared against a behavioural model.
module tb_servo_pwm_multi;

    localparam int NUM_CH  = 4;
    localparam int ANGLE_W = 11;
    localparam int PERIOD  = 100;
    localparam int DC_MIN  = 10;
    localparam int DC_MAX  = 90;
    localparam int DC_MID  = 50;
    localparam int NDUT    = 2;

    logic                      clk         = 1'b0;
    logic                      rst         = 1'b0;
    logic [NUM_CH*ANGLE_W-1:0] angle_flat  = '0;
    logic                      angle_valid = 1'b0;
    logic [NUM_CH-1:0]         ch_enable   = '0;
    logic                      ready        [NDUT];
    logic                      period_start [NDUT];
    logic [NUM_CH-1:0]         pwm_out      [NDUT];
    logic [NUM_CH-1:0]         settled      [NDUT];

    always #5 clk = ~clk;

    servo_pwm_multi #(
        .NUM_CH(NUM_CH), .CLK_FREQ(1000), .PWM_FREQ(10), .ANGLE_W(ANGLE_W),
        .ANGLE_MIN(-270), .ANGLE_MAX(270), .DC_MIN(DC_MIN), .DC_MAX(DC_MAX),
        .SLEW_STEP(0), .CNT_W(32)
    ) u_dut_jump (
        .clk(clk), .rst(rst), .angle_flat(angle_flat), .angle_valid(angle_valid),
        .ready(ready[0]), .ch_enable(ch_enable), .pwm_out(pwm_out[0]),
        .period_start(period_start[0]), .settled(settled[0])
    );

    servo_pwm_multi #(
        .NUM_CH(NUM_CH), .CLK_FREQ(1000), .PWM_FREQ(10), .ANGLE_W(ANGLE_W),
        .ANGLE_MIN(-270), .ANGLE_MAX(270), .DC_MIN(DC_MIN), .DC_MAX(DC_MAX),
        .SLEW_STEP(20), .CNT_W(32)
    ) u_dut_slew (
        .clk(clk), .rst(rst), .angle_flat(angle_flat), .angle_valid(angle_valid),
        .ready(ready[1]), .ch_enable(ch_enable), .pwm_out(pwm_out[1]),
        .period_start(period_start[1]), .settled(settled[1])
    );

    // Reference model state
    int cnt_m;
    int tgt_m  [NDUT][NUM_CH];
    int act_m  [NDUT][NUM_CH];
    bit en_m   [NUM_CH];
    int busy_m;
    int wr_ch_q[$];
    int wr_dc_q[$];
    int hi_acc [NDUT][NUM_CH];
    int w_exp  [NDUT][NUM_CH];

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s @%0t: got %0d expected %0d", tag, $time, got, exp);
        end
    endtask

    function automatic int slew_of(input int d);
        return (d == 0) ? 0 : 20;
    endfunction

    function automatic int map_dc(input int a);
        int c;
        c = (a < -270) ? -270 : ((a > 270) ? 270 : a);
        return DC_MIN + ((c + 270) * (DC_MAX - DC_MIN)) / 540;
    endfunction

    function automatic int slew_toward(input int act, input int tgt, input int stp);
        if (stp == 0) return tgt;
        if (tgt > act) return act + (((tgt - act) < stp) ? (tgt - act) : stp);
        if (tgt < act) return act - (((act - tgt) < stp) ? (act - tgt) : stp);
        return act;
    endfunction

    task automatic model_reset();
        cnt_m  = 0;
        busy_m = 0;
        wr_ch_q.delete();
        wr_dc_q.delete();
        for (int d = 0; d < NDUT; d++) begin
            for (int c = 0; c < NUM_CH; c++) begin
                tgt_m[d][c]  = DC_MID;
                act_m[d][c]  = DC_MID;
                hi_acc[d][c] = 0;
                w_exp[d][c]  = 0;
            end
        end
        for (int c = 0; c < NUM_CH; c++) en_m[c] = 1'b0;
    endtask

    task automatic compare_outputs();
        logic [NUM_CH-1:0] pwm_e;
        logic [NUM_CH-1:0] set_e;
        for (int d = 0; d < NDUT; d++) begin
            for (int c = 0; c < NUM_CH; c++) begin
                pwm_e[c] = en_m[c] && (cnt_m < act_m[d][c]);
                set_e[c] = (act_m[d][c] == tgt_m[d][c]);
            end
            check($sformatf("pwm_out[dut%0d]", d), 32'(pwm_out[d]), 32'(pwm_e));
            check($sformatf("settled[dut%0d]", d), 32'(settled[d]), 32'(set_e));
            check($sformatf("period_start[dut%0d]", d), 32'(period_start[d]), 32'(cnt_m == 0));
            check($sformatf("ready[dut%0d]", d), 32'(ready[d]), 32'(busy_m == 0));
            for (int c = 0; c < NUM_CH; c++) begin
                if (cnt_m == 0) begin
                    check($sformatf("width[dut%0d][ch%0d]", d, c), 32'(hi_acc[d][c]), 32'(w_exp[d][c]));
                    w_exp[d][c]  = en_m[c] ? act_m[d][c] : 0;
                    hi_acc[d][c] = int'(pwm_out[d][c]);
                end else begin
                    hi_acc[d][c] += int'(pwm_out[d][c]);
                end
            end
        end
    endtask

    // One clock: advance the model by the spec rules for that edge, then compare.
    task automatic step();
        int pre;
        bit acc;
        int a;
        pre = cnt_m;
        acc = angle_valid && (busy_m == 0);
        @(posedge clk);
        if (pre == PERIOD - 1) begin
            for (int c = 0; c < NUM_CH; c++) begin
                en_m[c] = ch_enable[c];
                for (int d = 0; d < NDUT; d++) act_m[d][c] = slew_toward(act_m[d][c], tgt_m[d][c], slew_of(d));
            end
        end
        if (wr_ch_q.size() > 0) begin
            int ch;
            int dc;
            ch = wr_ch_q.pop_front();
            dc = wr_dc_q.pop_front();
            for (int d = 0; d < NDUT; d++) tgt_m[d][ch] = dc;
        end
        if (busy_m > 0) busy_m--;
        if (acc) begin
            for (int c = 0; c < NUM_CH; c++) begin
                a = $signed(angle_flat[c*ANGLE_W +: ANGLE_W]);
                wr_ch_q.push_back(c);
                wr_dc_q.push_back(map_dc(a));
            end
            busy_m = NUM_CH + 1;
        end
        cnt_m = (pre + 1) % PERIOD;
        #1;
        compare_outputs();
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic run_until_cnt(input int c);
        for (int i = 0; i < PERIOD && cnt_m != c; i++) step();
    endtask

    task automatic wait_ready();
        for (int i = 0; i < 2 * NUM_CH + 4 && busy_m != 0; i++) step();
    endtask

    task automatic set_angles(input int a [NUM_CH]);
        for (int c = 0; c < NUM_CH; c++) angle_flat[c*ANGLE_W +: ANGLE_W] = ANGLE_W'(a[c]);
    endtask

    task automatic load(input int a [NUM_CH]);
        set_angles(a);
        angle_valid = 1'b1;
        step();
        angle_valid = 1'b0;
    endtask

    task automatic async_reset(input int hold);
        #1 rst = 1'b1;
        #1;
        for (int d = 0; d < NDUT; d++) begin
            check($sformatf("rst_pwm[dut%0d]", d), 32'(pwm_out[d]), 32'(0));
            check($sformatf("rst_pstart[dut%0d]", d), 32'(period_start[d]), 32'(0));
            check($sformatf("rst_ready[dut%0d]", d), 32'(ready[d]), 32'(1));
            check($sformatf("rst_settled[dut%0d]", d), 32'(settled[d]), 32'({NUM_CH{1'b1}}));
        end
        model_reset();
        repeat (hold) @(posedge clk);
        #2 rst = 1'b0;
    endtask

    task automatic random_angles();
        for (int c = 0; c < NUM_CH; c++) begin
            if ($urandom_range(0, 1) == 0)
                angle_flat[c*ANGLE_W +: ANGLE_W] = ANGLE_W'($urandom_range(0, 600) - 300);
            else
                angle_flat[c*ANGLE_W +: ANGLE_W] = ANGLE_W'($urandom);
        end
    endtask

    initial begin
        model_reset();
        async_reset(2);

        // Mid-point pulses on every channel once enabled
        ch_enable = '1;
        run(3 * PERIOD);

        // Clamped load; slew instance ramps over two periods
        wait_ready();
        load('{0, 270, -270, -300});
        run(4 * PERIOD);
        wait_ready();
        load('{270, 0, 0, -100});
        run(4 * PERIOD);

        // valid held through MAP with changing angles
        wait_ready();
        set_angles('{-135, 135, 200, -50});
        angle_valid = 1'b1;
        step();
        for (int i = 0; i < NUM_CH; i++) begin
            random_angles();
            step();
        end
        angle_valid = 1'b0;
        run(3 * PERIOD);

        // Enable dropped mid-pulse, restored later
        run_until_cnt(20);
        ch_enable[1] = 1'b0;
        run(2 * PERIOD);
        ch_enable[1] = 1'b1;
        run(2 * PERIOD);

        // Reset during the second MAP cycle
        wait_ready();
        load('{270, 270, 270, 270});
        step();
        async_reset(2);
        run(3 * PERIOD);

        for (int it = 0; it < 40; it++) begin
            run($urandom_range(1, 150));
            case ($urandom_range(0, 9))
                0, 1, 2: ch_enable = NUM_CH'($urandom);
                9: begin
                    random_angles();
                    angle_valid = 1'b1;
                    run($urandom_range(1, 3));
                    angle_valid = 1'b0;
                    async_reset($urandom_range(1, 3));
                end
                default: begin
                    random_angles();
                    angle_valid = 1'b1;
                    run($urandom_range(1, 7));
                    angle_valid = 1'b0;
                end
            endcase
        end
        run(4 * PERIOD);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
